// File: rtl/crop_engine_if.sv
// Job request, source-read, destination-write and status signals of the crop engine.
// The slave modport is the engine side; the master modport is the controller/memory side.
interface crop_engine_if #(
  parameter int PIX_W   = 24,
  parameter int ADDR_W  = 16,
  parameter int COORD_W = 10
);
  logic               start;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] crop_w;
  logic [COORD_W-1:0] crop_h;
  logic [1:0]         stride_log2;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [PIX_W-1:0]   rd_data;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [PIX_W-1:0]   wr_data;
  logic               busy;
  logic               done;
  logic               err;

  modport slave (
    input  start, x0, y0, crop_w, crop_h, stride_log2, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport master (
    output start, x0, y0, crop_w, crop_h, stride_log2, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/crop_engine.sv
// Copies a (optionally decimated) rectangular window of a source image into a
// densely packed destination buffer, one pixel per cycle.
module crop_engine #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int PIX_W   = 24,
  parameter int ADDR_W  = 16,
  parameter int COORD_W = 10
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  crop_engine_if.slave  bus
);

  // Scan coordinates carry two spare bits so x+S and y+S never wrap.
  localparam int SW = COORD_W + 2;

  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, FIN} state_t;
  state_t state, state_nxt;

  logic [COORD_W-1:0] x0_q, y0_q, w_q, h_q;
  logic [1:0]         stride_q;
  logic               err_q;
  logic [SW-1:0]      x_p0, y_p0;
  logic               vld_p0, vld_p1;
  logic [ADDR_W-1:0]  wr_idx_p1;
  logic [SW-1:0]      step, x_end, y_end, x_adv, y_adv;
  logic               row_last, frame_last, reject;
  logic [ADDR_W-1:0]  addr_p0;

  function automatic logic window_bad(input logic [COORD_W-1:0] base,
                                      input logic [COORD_W-1:0] size,
                                      input int limit);
    logic [COORD_W:0] sum;
    sum = {1'b0, base} + {1'b0, size};
    return (size == '0) || (sum > (COORD_W+1)'(limit));
  endfunction

  always_comb begin
    reject     = window_bad(x0_q, w_q, IMG_W) || window_bad(y0_q, h_q, IMG_H) ||
                 (stride_q == 2'd3);
    step       = SW'(1) << stride_q;
    x_end      = SW'(x0_q) + SW'(w_q);
    y_end      = SW'(y0_q) + SW'(h_q);
    x_adv      = x_p0 + step;
    y_adv      = y_p0 + step;
    row_last   = (x_adv >= x_end);
    frame_last = row_last && (y_adv >= y_end);
    addr_p0    = ADDR_W'(32'(y_p0) * 32'(IMG_W) + 32'(x_p0));
  end

  always_comb begin
    state_nxt = state;
    vld_p0    = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_nxt = CHECK;
      CHECK:   state_nxt = reject ? FIN : RUN;
      RUN: begin
        vld_p0 = 1'b1;
        if (frame_last) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: read issue / scan counters; stage p1: write of the returned pixel.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      x_p0      <= '0;
      y_p0      <= '0;
      vld_p1    <= 1'b0;
      wr_idx_p1 <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= vld_p0;
      if (vld_p1) wr_idx_p1 <= wr_idx_p1 + ADDR_W'(1);
      case (state)
        IDLE: if (bus.start) begin
          err_q     <= 1'b0;
          wr_idx_p1 <= '0;
        end
        CHECK: begin
          x_p0 <= SW'(x0_q);
          y_p0 <= SW'(y0_q);
          if (reject) err_q <= 1'b1;
        end
        RUN: begin
          if (row_last) begin
            x_p0 <= SW'(x0_q);
            y_p0 <= y_adv;
          end else begin
            x_p0 <= x_adv;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset && state == IDLE && bus.start) begin
      x0_q     <= bus.x0;
      y0_q     <= bus.y0;
      w_q      <= bus.crop_w;
      h_q      <= bus.crop_h;
      stride_q <= bus.stride_log2;
    end
  end

  assign bus.rd_en   = vld_p0;
  assign bus.rd_addr = vld_p0 ? addr_p0 : '0;
  assign bus.wr_en   = vld_p1;
  assign bus.wr_addr = vld_p1 ? wr_idx_p1 : '0;
  assign bus.wr_data = vld_p1 ? bus.rd_data : PIX_W'(0);
  assign bus.busy    = (state == CHECK) || (state == RUN) || (state == DRAIN);
  assign bus.done    = (state == FIN);
  assign bus.err     = err_q;

endmodule

// File: tb/tb_crop_engine.sv
// Bench for crop_engine on an 8x8 image: directed and random jobs compared
// against a raster-scan model of the expected reads, writes and timing.
module tb_crop_engine;
  localparam int IW = 8, IH = 8, PW = 24, AW = 6, CW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  crop_engine_if #(.PIX_W(PW), .ADDR_W(AW), .COORD_W(CW)) bus ();

  crop_engine #(.IMG_W(IW), .IMG_H(IH), .PIX_W(PW), .ADDR_W(AW), .COORD_W(CW)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  logic [PW-1:0] src [IW*IH];

  // Source memory: one-cycle read latency, garbage on idle cycles.
  always @(posedge clk)
    bus.rd_data <= bus.rd_en ? src[bus.rd_addr] : PW'($urandom);

  int tests = 0, fails = 0;
  int exp_addr[$];
  int exp_n, exp_done;
  bit exp_ok;
  int rd_n, wr_n, rd_bad, wr_bad, gate_bad, busy_bad, done_cyc, err_done, err_c1;
  int last_rd, last_wr, rst_bad, quiet_bad;

  task automatic model_job(input int x0, input int y0, input int w, input int h, input int s);
    int st;
    st = 1 << s;
    exp_addr.delete();
    exp_ok = !(w == 0 || h == 0 || x0 + w > IW || y0 + h > IH || s == 3);
    if (exp_ok)
      for (int yy = y0; yy < y0 + h; yy += st)
        for (int xx = x0; xx < x0 + w; xx += st)
          exp_addr.push_back(yy * IW + xx);
    exp_n    = exp_addr.size();
    exp_done = exp_ok ? exp_n + 3 : 2;
  endtask

  task automatic run_job(input int x0, input int y0, input int w, input int h, input int s,
                         input int restart_cyc, input int rst_cyc);
    int cyc, idx;
    bit fin;
    model_job(x0, y0, w, h, s);
    rd_n = 0; wr_n = 0; rd_bad = 0; wr_bad = 0; gate_bad = 0; busy_bad = 0;
    done_cyc = -1; err_done = -1; err_c1 = -1; last_rd = -1; last_wr = -1;
    rst_bad = 0; quiet_bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x0 = CW'(x0); bus.y0 = CW'(y0); bus.crop_w = CW'(w); bus.crop_h = CW'(h);
    bus.stride_log2 = 2'(s);
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == restart_cyc);
      bus.x0 = CW'($urandom); bus.y0 = CW'($urandom);
      bus.crop_w = CW'($urandom); bus.crop_h = CW'($urandom);
      bus.stride_log2 = 2'($urandom);
      if (cyc == 1) err_c1 = int'(bus.err);
      if (rst_cyc > 0 && cyc > rst_cyc) begin
        if (bus.busy || bus.done || bus.err || bus.rd_en || bus.wr_en ||
            bus.rd_addr != '0 || bus.wr_addr != '0 || bus.wr_data != '0) rst_bad++;
        reset = 1'b0;
        fin = 1'b1;
      end else begin
        if (bus.rd_en) begin
          idx = rd_n;
          if (idx >= exp_n) rd_bad++;
          else if (int'(bus.rd_addr) != exp_addr[idx] || cyc != idx + 2) rd_bad++;
          rd_n++;
          last_rd = int'(bus.rd_addr);
        end else if (bus.rd_addr !== '0) gate_bad++;
        if (bus.wr_en) begin
          idx = wr_n;
          if (idx >= exp_n) wr_bad++;
          else if (int'(bus.wr_addr) != idx || bus.wr_data !== src[exp_addr[idx]] || cyc != idx + 3)
            wr_bad++;
          wr_n++;
          last_wr = int'(bus.wr_addr);
        end else if (bus.wr_addr !== '0 || bus.wr_data !== '0) gate_bad++;
        if (bus.busy !== (cyc < exp_done)) busy_bad++;
        if (bus.done) begin
          done_cyc = cyc;
          err_done = int'(bus.err);
          fin = 1'b1;
        end
        if (cyc == rst_cyc) reset = 1'b1;
      end
    end
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.rd_en || bus.wr_en) quiet_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.x0 = '0; bus.y0 = '0; bus.crop_w = CW'(2); bus.crop_h = CW'(2); bus.stride_log2 = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
    tests++; if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin fails++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", bus.rd_en, bus.wr_en); end
  endtask

  task automatic test_basic();
    run_job(2, 1, 3, 2, 0, -1, -1);
    tests++; if (rd_n !== 6) begin fails++; $display("FAIL basic_rd_count: got %0d want 6", rd_n); end
    tests++; if (rd_bad !== 0) begin fails++; $display("FAIL basic_rd_seq: got %0d bad reads want 0", rd_bad); end
    tests++; if (wr_n !== 6) begin fails++; $display("FAIL basic_wr_count: got %0d want 6", wr_n); end
    tests++; if (wr_bad !== 0) begin fails++; $display("FAIL basic_wr_seq: got %0d bad writes want 0", wr_bad); end
    tests++; if (gate_bad !== 0) begin fails++; $display("FAIL basic_gating: got %0d nonzero idle buses want 0", gate_bad); end
    tests++; if (busy_bad !== 0) begin fails++; $display("FAIL basic_busy: got %0d bad cycles want 0", busy_bad); end
    tests++; if (done_cyc !== 9) begin fails++; $display("FAIL basic_done_cycle: got %0d want 9", done_cyc); end
    tests++; if (err_done !== 0) begin fails++; $display("FAIL basic_err: got %0d want 0", err_done); end
    tests++; if (quiet_bad !== 0) begin fails++; $display("FAIL basic_after_done: got %0d active cycles want 0", quiet_bad); end
  endtask

  task automatic test_decimate();
    run_job(0, 0, 3, 3, 1, -1, -1);
    tests++; if (rd_n !== 4) begin fails++; $display("FAIL dec_rd_count: got %0d want 4", rd_n); end
    tests++; if (rd_bad !== 0) begin fails++; $display("FAIL dec_rd_seq: got %0d bad reads want 0", rd_bad); end
    tests++; if (wr_n !== 4 || wr_bad !== 0) begin fails++; $display("FAIL dec_writes: got %0d writes %0d bad want 4 0", wr_n, wr_bad); end
    tests++; if (done_cyc !== 7) begin fails++; $display("FAIL dec_done_cycle: got %0d want 7", done_cyc); end
  endtask

  task automatic test_reject();
    run_job(6, 0, 3, 2, 0, -1, -1);
    tests++; if (done_cyc !== 2) begin fails++; $display("FAIL rej_done_cycle: got %0d want 2", done_cyc); end
    tests++; if (err_done !== 1) begin fails++; $display("FAIL rej_err: got %0d want 1", err_done); end
    tests++; if (rd_n !== 0 || wr_n !== 0) begin fails++; $display("FAIL rej_strobes: got rd=%0d wr=%0d want 0 0", rd_n, wr_n); end
    tests++; if (busy_bad !== 0) begin fails++; $display("FAIL rej_busy: got %0d bad cycles want 0", busy_bad); end
    repeat (3) @(negedge clk);
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL rej_err_hold: got %b want 1", bus.err); end
    run_job(0, 0, 2, 2, 3, -1, -1);
    tests++; if (err_c1 !== 0) begin fails++; $display("FAIL rej_err_clear: got %0d want 0", err_c1); end
    tests++; if (done_cyc !== 2 || err_done !== 1) begin fails++; $display("FAIL rej_stride3: got done@%0d err=%0d want done@2 err=1", done_cyc, err_done); end
    tests++; if (rd_n !== 0 || wr_n !== 0) begin fails++; $display("FAIL rej_stride3_strobes: got rd=%0d wr=%0d want 0 0", rd_n, wr_n); end
  endtask

  task automatic test_full_frame();
    run_job(0, 0, IW, IH, 0, -1, -1);
    tests++; if (wr_n !== 64 || wr_bad !== 0) begin fails++; $display("FAIL full_writes: got %0d writes %0d bad want 64 0", wr_n, wr_bad); end
    tests++; if (rd_bad !== 0) begin fails++; $display("FAIL full_rd_seq: got %0d bad reads want 0", rd_bad); end
    tests++; if (last_rd !== 63) begin fails++; $display("FAIL full_last_rd: got %0d want 63", last_rd); end
    tests++; if (last_wr !== 63) begin fails++; $display("FAIL full_last_wr: got %0d want 63", last_wr); end
    tests++; if (done_cyc !== 67 || err_done !== 0) begin fails++; $display("FAIL full_done: got done@%0d err=%0d want done@67 err=0", done_cyc, err_done); end
  endtask

  task automatic test_restart();
    run_job(2, 1, 3, 2, 0, 4, -1);
    tests++; if (rd_n !== 6 || rd_bad !== 0) begin fails++; $display("FAIL restart_reads: got %0d reads %0d bad want 6 0", rd_n, rd_bad); end
    tests++; if (wr_n !== 6 || wr_bad !== 0) begin fails++; $display("FAIL restart_writes: got %0d writes %0d bad want 6 0", wr_n, wr_bad); end
    tests++; if (done_cyc !== 9) begin fails++; $display("FAIL restart_done_cycle: got %0d want 9", done_cyc); end
    tests++; if (quiet_bad !== 0) begin fails++; $display("FAIL restart_after_done: got %0d active cycles want 0", quiet_bad); end
  endtask

  task automatic test_reset_mid_run();
    run_job(0, 0, IW, IH, 0, -1, 5);
    tests++; if (rst_bad !== 0) begin fails++; $display("FAIL midrst_outputs: got %0d nonzero want 0", rst_bad); end
    tests++; if (rd_n !== 4 || rd_bad !== 0) begin fails++; $display("FAIL midrst_reads: got %0d reads %0d bad want 4 0", rd_n, rd_bad); end
    tests++; if (quiet_bad !== 0 || done_cyc !== -1) begin fails++; $display("FAIL midrst_quiet: got %0d active done@%0d want 0 none", quiet_bad, done_cyc); end
    run_job(2, 1, 3, 2, 0, -1, -1);
    tests++; if (rd_n !== 6 || rd_bad !== 0 || wr_n !== 6 || wr_bad !== 0) begin fails++; $display("FAIL midrst_next_job: got rd=%0d/%0d wr=%0d/%0d want 6/0 6/0", rd_n, rd_bad, wr_n, wr_bad); end
    tests++; if (done_cyc !== 9 || err_done !== 0) begin fails++; $display("FAIL midrst_next_done: got done@%0d err=%0d want done@9 err=0", done_cyc, err_done); end
  endtask

  task automatic test_random();
    int x0, y0, w, h, s;
    for (int k = 0; k < 16; k++) begin
      x0 = $urandom_range(0, 8); y0 = $urandom_range(0, 8);
      w  = $urandom_range(0, 8); h  = $urandom_range(0, 8);
      s  = $urandom_range(0, 3);
      run_job(x0, y0, w, h, s, -1, -1);
      tests++; if (rd_n !== exp_n || rd_bad !== 0) begin fails++; $display("FAIL rnd%0d_reads: got %0d reads %0d bad want %0d 0", k, rd_n, rd_bad, exp_n); end
      tests++; if (wr_n !== exp_n || wr_bad !== 0) begin fails++; $display("FAIL rnd%0d_writes: got %0d writes %0d bad want %0d 0", k, wr_n, wr_bad, exp_n); end
      tests++; if (gate_bad !== 0 || busy_bad !== 0) begin fails++; $display("FAIL rnd%0d_status: got gate=%0d busy=%0d bad want 0 0", k, gate_bad, busy_bad); end
      tests++; if (done_cyc !== exp_done || err_done !== (exp_ok ? 0 : 1)) begin fails++; $display("FAIL rnd%0d_done: got done@%0d err=%0d want done@%0d err=%0d", k, done_cyc, err_done, exp_done, exp_ok ? 0 : 1); end
    end
  endtask

  initial begin
    for (int i = 0; i < IW * IH; i++) src[i] = PW'($urandom);
    bus.start = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.crop_w = '0; bus.crop_h = '0; bus.stride_log2 = 2'd0;
    test_reset();
    test_basic();
    test_decimate();
    test_reject();
    test_full_frame();
    test_restart();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/crop_engine.md
CROP_ENGINE -- requirements
Module: crop_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 256, source image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 256, source image height in pixels.
REQ-003 SHALL have parameter PIX_W, default 24, pixel data width in bits.
REQ-004 SHALL have parameter ADDR_W, default 16, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 SHALL have parameter COORD_W, default 10, width of coordinate and size inputs; must satisfy 2^COORD_W > max(IMG_W, IMG_H).
REQ-006 SHALL have the following ports:
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a crop.
- x0, y0  in  COORD_W each  top-left corner of the crop window.
- crop_w, crop_h  in  COORD_W each  crop window size in pixels.
- stride_log2  in  2  decimation: 0 = every pixel, 1 = every 2nd, 2 = every 4th; 3 is reserved.
- rd_en  out  1  source-memory read strobe.
- rd_addr  out  ADDR_W  source address.
- rd_data  in  PIX_W  source data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  destination-memory write strobe.
- wr_addr  out  ADDR_W  destination address.
- wr_data  out  PIX_W  destination data.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  last job rejected.

Function
REQ-007 SHALL implement the states IDLE, CHECK, RUN, DRAIN and FIN.
REQ-008 In IDLE, start=1 SHALL latch x0, y0, crop_w, crop_h and stride_log2, clear err, and move to CHECK.
REQ-009 start SHALL be ignored in every state other than IDLE; latched parameters SHALL be unaffected by input changes after the latch.
REQ-010 CHECK SHALL reject the job when any of the following holds: crop_w=0, crop_h=0, x0+crop_w>IMG_W, y0+crop_h>IMG_H, or stride_log2=3.
- All sums SHALL be computed at COORD_W+1 bits so they cannot overflow.
- On reject: move to FIN with err set; no rd_en or wr_en is issued.
REQ-011 A valid job SHALL move CHECK->RUN.
REQ-012 RUN SHALL issue one read per cycle, rd_en=1, with rd_addr = y*IMG_W + x.
- Scan is raster order: x from x0 to x0+crop_w-1 in steps of S=2^stride_log2, inner loop; y from y0 to y0+crop_h-1 in steps of S, outer loop.
REQ-013 The output pixel count SHALL be N = ceil(crop_w/S)*ceil(crop_h/S).
REQ-014 For each read issued at cycle t, the block SHALL assert wr_en at t+1 with wr_data=rd_data and wr_addr = write index.
- Write index counts 0..N-1 in order, so output is packed at row pitch ceil(crop_w/S).
REQ-015 After the last read, the state SHALL move to DRAIN for one cycle, which performs the final write, then to FIN.
REQ-016 FIN SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-017 busy SHALL be 1 in CHECK, RUN and DRAIN, and 0 in IDLE and FIN.
REQ-018 err SHALL remain set after FIN until the next accepted start or reset.
REQ-019 Timing with start sampled at edge 0 of a valid job:
- first rd_en at cycle 2, first wr_en at cycle 3;
- last rd_en at cycle N+1, last wr_en at cycle N+2;
- done at cycle N+3.
REQ-020 Timing with start sampled at edge 0 of a rejected job: done=1 and err=1 at cycle 2.
REQ-021 rd_addr, wr_addr and wr_data SHALL be 0 whenever their respective strobe is 0.
REQ-022 A full-frame crop (x0=y0=0, crop_w=IMG_W, crop_h=IMG_H) SHALL be accepted; its last rd_addr SHALL be IMG_W*IMG_H-1, with no address wrap.

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE and clear busy, done, err, rd_en, wr_en, rd_addr, wr_addr, wr_data and all counters.
- This applies in any state, including mid-RUN.
- No further strobes SHALL occur until a new start.
REQ-024 start SHALL be ignored while reset=1.

Verification (IMG_W=IMG_H=8)
REQ-025 Basic crop: x0=2, y0=1, w=3, h=2, stride 0 -> rd_addr 10,11,12,18,19,20 at cycles 2-7; wr_addr 0-5 at cycles 3-8 carrying matching data; done at cycle 9; err=0.
REQ-026 Decimated crop: x0=0, y0=0, w=3, h=3, stride 1 -> rd_addr 0,2,16,18; 4 writes to wr_addr 0-3; done at cycle 7.
REQ-027 Reject: x0=6, w=3 -> err=1 and done=1 at cycle 2; zero rd_en and wr_en; err held until the next start; a second reject with stride_log2=3 behaves the same.
REQ-028 Full frame, stride 0 -> 64 writes; last rd_addr 63; last wr_addr 63; done at cycle 67.
REQ-029 start pulsed again at cycle 4 of the REQ-025 job -> ignored; output identical to REQ-025.
REQ-030 reset at cycle 5 of the REQ-028 job -> all outputs 0 at the next edge; a new job launched afterwards completes per REQ-025.
